// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline register between two processor stages. Carries a
//   control bundle and a data bundle through DEPTH register slots. Slot 0
//   sits on the input side and slot DEPTH-1 drives the outputs. An invalid
//   slot always presents an all-zero control bundle, which is a NOP bubble
//   to the next stage.
//
//   Handshake: a beat moves on any cycle where valid and ready are both 1.
//   in_ready_o never depends on in_valid_i. out_valid_o never waits for
//   out_ready_i. in_ready_o is combinational from out_ready_i through the
//   slot advance chain, which gives full throughput.
//
// Parameters
//   DATA_W      width of the data bundle
//   CTRL_W      width of the control bundle
//   DEPTH       number of register slots (1..8)
//   CLEAR_DATA  1: a flush also zeroes data. 0: a flush clears valid/ctrl only.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   in_valid_i   upstream presents a beat
//   in_ready_o   block accepts the beat this cycle
//   in_ctrl_i    control bundle in
//   in_data_i    data bundle in
//   out_valid_o  last slot holds a valid beat (masked while stalled)
//   out_ready_i  downstream takes the beat
//   out_ctrl_o   control of the last slot, zero when out_valid_o is 0
//   out_data_o   data of the last slot, not masked
//   stall_i      freeze every slot
//   flush_i      kill every in-flight beat (overrides stall_i)
//   occupancy_o  number of valid slots, registered
module pipe_stage_elastic #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 16,
  parameter int DEPTH      = 1,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [CTRL_W-1:0]          in_ctrl_i,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CTRL_W-1:0]          out_ctrl_o,
  output logic [DATA_W-1:0]          out_data_o,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  v_d;
  logic [DEPTH-1:0]  adv;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;

  // A slot may load when it is empty or when the slot after it moves.
  // Evaluating from the output side toward the input gives the ripple.
  // Because empty slots always advance, gaps close under backpressure.
  always_comb begin
    logic chain;
    chain = out_ready_i;
    adv   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain  = ~v_q[k] | chain;
      adv[k] = chain;
    end
  end

  // Next slot contents. Flush wins over stall. Stall freezes everything.
  // An advancing slot copies its upstream neighbour whole, including the
  // data of an invalid neighbour.
  always_comb begin
    v_d    = v_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (flush_i) begin
      v_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_d[k] = '0;
        if (CLEAR_DATA) begin
          data_d[k] = '0;
        end
      end
    end else if (!stall_i) begin
      if (adv[0]) begin
        v_d[0]    = in_valid_i;
        ctrl_d[0] = in_ctrl_i;
        data_d[0] = in_data_i;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          v_d[k]    = v_q[k-1];
          ctrl_d[k] = ctrl_q[k-1];
          data_d[k] = data_q[k-1];
        end
      end
    end
  end

  // Occupancy is the population count of the next valid vector. It is
  // registered alongside the slots, so it always matches them.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= ctrl_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  // During a flush the last slot still shows valid, even if stalled. The
  // downstream stage sees the same flush and drops that beat itself.
  assign out_valid_o = v_q[DEPTH-1] & (flush_i | ~stall_i);
  assign out_ctrl_o  = out_valid_o ? ctrl_q[DEPTH-1] : '0;
  assign out_data_o  = data_q[DEPTH-1];
  // Gating with rst_i holds ready low during reset, when the cleared slots
  // would otherwise report ready.
  assign in_ready_o  = rst_i & ~stall_i & ~flush_i & adv[0];
  assign occupancy_o = occ_q;

endmodule
